// File: rtl/fft32_bfly_scheduler.sv
// Purpose: address/twiddle sequencer for an in-place 32-point radix-2 DIT FFT.
// Latency: first read 1 cycle after start; done 5*(16+RD_LAT)+1 cycles after start.
// Backpressure: none; start is ignored while busy, abort or reset cancels the run.
module fft32_bfly_scheduler #(
    parameter int N_LOG2 = 5,
    parameter int ADDR_W = N_LOG2,
    parameter int TW_W   = N_LOG2 - 1,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    output logic [TW_W-1:0]   tw_idx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr_a,
    output logic [ADDR_W-1:0] wr_addr_b,
    output logic [2:0]        stage,
    output logic              busy,
    output logic              done
);

    localparam int BF_W = N_LOG2 - 1;
    localparam int DC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [2:0] LAST_STAGE = 3'(N_LOG2 - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] b;
    } wb_t;

    state_t            state;
    logic [BF_W-1:0]   bfly;
    logic [DC_W-1:0]   drain_cnt;
    wb_t               dly_q [RD_LAT];

    logic [2:0]        iss_s;
    logic [BF_W-1:0]   iss_j;
    logic [ADDR_W-1:0] iss_a;
    logic [ADDR_W-1:0] iss_b;
    logic [TW_W-1:0]   iss_tw;

    function automatic logic [ADDR_W-1:0] span_of(input logic [2:0] s);
        return ADDR_W'(1) << s;
    endfunction

    // Top operand: group base (grp * 2 * span) plus position inside the group.
    function automatic logic [ADDR_W-1:0] addr_a_of(input logic [2:0] s,
                                                    input logic [BF_W-1:0] j);
        logic [ADDR_W-1:0] grp;
        logic [ADDR_W-1:0] pos;
        grp = ADDR_W'(j) >> s;
        pos = ADDR_W'(j) & (span_of(s) - ADDR_W'(1));
        return (grp << (s + 3'd1)) | pos;
    endfunction

    function automatic logic [TW_W-1:0] tw_of(input logic [2:0] s,
                                              input logic [BF_W-1:0] j);
        logic [ADDR_W-1:0] pos;
        pos = ADDR_W'(j) & (span_of(s) - ADDR_W'(1));
        return TW_W'(pos << (LAST_STAGE - s));
    endfunction

    // Butterfly that would be issued on the next edge if the FSM chooses to issue.
    always_comb begin
        iss_s = stage;
        iss_j = bfly + BF_W'(1);
        if (state == S_IDLE) begin
            iss_s = 3'd0;
            iss_j = '0;
        end else if (state == S_DRAIN) begin
            iss_s = stage + 3'd1;
            iss_j = '0;
        end
        iss_a  = addr_a_of(iss_s, iss_j);
        iss_b  = iss_a + span_of(iss_s);
        iss_tw = tw_of(iss_s, iss_j);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            state     <= S_IDLE;
            stage     <= 3'd0;
            bfly      <= '0;
            drain_cnt <= '0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_idx    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        stage     <= 3'd0;
                        bfly      <= '0;
                        rd_en     <= 1'b1;
                        rd_addr_a <= iss_a;
                        rd_addr_b <= iss_b;
                        tw_idx    <= iss_tw;
                        busy      <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bfly == '1) begin
                        state     <= S_DRAIN;
                        drain_cnt <= '0;
                        rd_en     <= 1'b0;
                        rd_addr_a <= '0;
                        rd_addr_b <= '0;
                        tw_idx    <= '0;
                    end else begin
                        bfly      <= iss_j;
                        rd_addr_a <= iss_a;
                        rd_addr_b <= iss_b;
                        tw_idx    <= iss_tw;
                    end
                end
                S_DRAIN: begin
                    // Holding reads off for RD_LAT cycles lets the last write land first.
                    if (drain_cnt == DC_W'(RD_LAT - 1)) begin
                        drain_cnt <= '0;
                        if (stage == LAST_STAGE) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= S_RUN;
                            stage     <= iss_s;
                            bfly      <= '0;
                            rd_en     <= 1'b1;
                            rd_addr_a <= iss_a;
                            rd_addr_b <= iss_b;
                            tw_idx    <= iss_tw;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + DC_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    stage <= 3'd0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write-back delay line: matches the RAM read latency, flushed on cancel.
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            for (int k = 0; k < RD_LAT; k++) dly_q[k] <= '0;
        end else begin
            dly_q[0] <= '{vld: rd_en, a: rd_addr_a, b: rd_addr_b};
            for (int k = 1; k < RD_LAT; k++) dly_q[k] <= dly_q[k-1];
        end
    end

    assign wr_en     = dly_q[RD_LAT-1].vld;
    assign wr_addr_a = dly_q[RD_LAT-1].a;
    assign wr_addr_b = dly_q[RD_LAT-1].b;

endmodule

// File: tb/tb_fft32_bfly_scheduler.sv
// Directed bench for fft32_bfly_scheduler: logs every cycle of a run, then
// checks against hand-computed values and a nested-loop butterfly ordering.
module tb_fft32_bfly_scheduler;

    localparam int NL = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;

    logic       rd_en, wr_en, busy, done;
    logic [4:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [3:0] tw_idx;
    logic [2:0] stage;

    logic       rd_en1, wr_en1, busy1, done1;
    logic [4:0] rd_addr_a1, rd_addr_b1, wr_addr_a1, wr_addr_b1;
    logic [3:0] tw_idx1;
    logic [2:0] stage1;

    logic       rd_en4, wr_en4, busy4, done4;
    logic [4:0] rd_addr_a4, rd_addr_b4, wr_addr_a4, wr_addr_b4;
    logic [3:0] tw_idx4;
    logic [2:0] stage4;

    fft32_bfly_scheduler #(.RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
        .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
        .stage(stage), .busy(busy), .done(done)
    );

    fft32_bfly_scheduler #(.RD_LAT(1)) dut_lat1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rd_en(rd_en1), .rd_addr_a(rd_addr_a1), .rd_addr_b(rd_addr_b1), .tw_idx(tw_idx1),
        .wr_en(wr_en1), .wr_addr_a(wr_addr_a1), .wr_addr_b(wr_addr_b1),
        .stage(stage1), .busy(busy1), .done(done1)
    );

    fft32_bfly_scheduler #(.RD_LAT(4)) dut_lat4 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rd_en(rd_en4), .rd_addr_a(rd_addr_a4), .rd_addr_b(rd_addr_b4), .tw_idx(tw_idx4),
        .wr_en(wr_en4), .wr_addr_a(wr_addr_a4), .wr_addr_b(wr_addr_b4),
        .stage(stage4), .busy(busy4), .done(done4)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic rd_l [NL];
    logic wr_l [NL];
    logic done_l [NL];
    logic busy_l [NL];
    logic d1_l [NL];
    logic d4_l [NL];
    int   a_l [NL];
    int   b_l [NL];
    int   tw_l [NL];
    int   wa_l [NL];
    int   wb_l [NL];
    int   st_l [NL];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic record();
        if (cyc >= 0 && cyc < NL) begin
            rd_l[cyc]   = rd_en;
            wr_l[cyc]   = wr_en;
            done_l[cyc] = done;
            busy_l[cyc] = busy;
            d1_l[cyc]   = done1;
            d4_l[cyc]   = done4;
            a_l[cyc]    = int'(rd_addr_a);
            b_l[cyc]    = int'(rd_addr_b);
            tw_l[cyc]   = int'(tw_idx);
            wa_l[cyc]   = int'(wr_addr_a);
            wb_l[cyc]   = int'(wr_addr_b);
            st_l[cyc]   = int'(stage);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        record();
    endtask

    // Cycle 0 is the cycle in which start is presented.
    task automatic begin_run();
        for (int c = 0; c < NL; c++) begin
            rd_l[c] = 1'b0; wr_l[c] = 1'b0; done_l[c] = 1'b0; busy_l[c] = 1'b0;
            d1_l[c] = 1'b0; d4_l[c] = 1'b0;
            a_l[c] = 0; b_l[c] = 0; tw_l[c] = 0; wa_l[c] = 0; wb_l[c] = 0; st_l[c] = 0;
        end
        cyc = 0;
        record();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic int count_of(input int sel, input int lo, input int hi);
        int n;
        n = 0;
        for (int c = lo; c <= hi; c++) begin
            case (sel)
                0:       if (rd_l[c] === 1'b1) n++;
                1:       if (wr_l[c] === 1'b1) n++;
                default: if (done_l[c] === 1'b1) n++;
            endcase
        end
        return n;
    endfunction

    function automatic int first_high(input int sel);
        for (int c = 0; c < NL; c++) begin
            if (sel == 1 && d1_l[c] === 1'b1) return c;
            if (sel == 4 && d4_l[c] === 1'b1) return c;
        end
        return -1;
    endfunction

    // Classic DIT loop: groups of 2*span, butterflies inside a group at distance span.
    task automatic check_golden(input int base);
        int span, j, c, ea, eb, etw;
        for (int s = 0; s < 5; s++) begin
            span = 1 << s;
            j = 0;
            for (int gb = 0; gb < 32; gb += 2 * span) begin
                for (int pos = 0; pos < span; pos++) begin
                    c   = base + s * 18 + j;
                    ea  = gb + pos;
                    eb  = ea + span;
                    etw = pos * (16 / span);
                    check_eq($sformatf("rd_en s%0dj%0d", s, j), rd_l[c], 1);
                    check_eq($sformatf("rd_a s%0dj%0d", s, j), a_l[c], ea);
                    check_eq($sformatf("rd_b s%0dj%0d", s, j), b_l[c], eb);
                    check_eq($sformatf("tw s%0dj%0d", s, j), tw_l[c], etw);
                    check_eq($sformatf("stage s%0dj%0d", s, j), st_l[c], s);
                    check_eq($sformatf("wr_en s%0dj%0d", s, j), wr_l[c+2], 1);
                    check_eq($sformatf("wr_a s%0dj%0d", s, j), wa_l[c+2], ea);
                    check_eq($sformatf("wr_b s%0dj%0d", s, j), wb_l[c+2], eb);
                    j++;
                end
            end
        end
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        check_eq("rst rd_en", rd_en, 0);
        check_eq("rst wr_en", wr_en, 0);
        check_eq("rst busy", busy, 0);
        check_eq("rst done", done, 0);
        check_eq("rst stage", stage, 0);
        check_eq("rst rd_a", rd_addr_a, 0);
        rst_n = 1'b1;
        tick();

        // Run 1: clean full run
        begin_run();
        repeat (110) tick();
        check_eq("c1 rd_en", rd_l[1], 1);
        check_eq("c1 a", a_l[1], 0);
        check_eq("c1 b", b_l[1], 1);
        check_eq("c1 tw", tw_l[1], 0);
        check_eq("c1 stage", st_l[1], 0);
        check_eq("c1 busy", busy_l[1], 1);
        check_eq("c2 wr_en", wr_l[2], 0);
        check_eq("c3 wr_en", wr_l[3], 1);
        check_eq("c3 wr_a", wa_l[3], 0);
        check_eq("c3 wr_b", wb_l[3], 1);
        check_eq("s1j3 a", a_l[22], 5);
        check_eq("s1j3 b", b_l[22], 7);
        check_eq("s1j3 tw", tw_l[22], 8);
        check_eq("s2j5 a", a_l[42], 9);
        check_eq("s2j5 b", b_l[42], 13);
        check_eq("s2j5 tw", tw_l[42], 4);
        check_eq("s4j3 a", a_l[76], 3);
        check_eq("s4j3 b", b_l[76], 19);
        check_eq("s4j3 tw", tw_l[76], 3);
        check_golden(1);
        check_eq("rd count", count_of(0, 0, 110), 80);
        check_eq("wr count", count_of(1, 0, 110), 80);
        check_eq("done count", count_of(2, 0, 110), 1);
        check_eq("done c90", done_l[90], 0);
        check_eq("done c91", done_l[91], 1);
        check_eq("busy c91", busy_l[91], 1);
        check_eq("busy c92", busy_l[92], 0);
        check_eq("stage c92", st_l[92], 0);
        check_eq("drain rd c17", rd_l[17], 0);
        check_eq("drain rd c18", rd_l[18], 0);
        check_eq("drain stage c18", st_l[18], 0);
        check_eq("drain busy c18", busy_l[18], 1);
        check_eq("last s0 wr c18", wr_l[18], 1);
        check_eq("last s0 wr_a", wa_l[18], 30);
        check_eq("first s1 rd c19", rd_l[19], 1);
        check_eq("s1 stage c19", st_l[19], 1);
        check_eq("wr c19", wr_l[19], 0);
        check_eq("lat1 done cyc", first_high(1), 86);
        check_eq("lat4 done cyc", first_high(4), 101);

        // Run 2: stray starts at 10 and 91 ignored, start at 92 launches a new run
        begin_run();
        for (int c = 0; c < 199; c++) begin
            tick();
            start = (cyc == 10 || cyc == 91 || cyc == 92);
        end
        start = 1'b0;
        check_eq("r2 a c11", a_l[11], 20);
        check_eq("r2 done c91", done_l[91], 1);
        check_eq("r2 busy c92", busy_l[92], 0);
        check_eq("r2 rd c92", rd_l[92], 0);
        check_eq("r2 rd count 1st", count_of(0, 0, 92), 80);
        check_eq("r2 done 1st", count_of(2, 0, 92), 1);
        check_eq("r2 c93 rd", rd_l[93], 1);
        check_eq("r2 c93 a", a_l[93], 0);
        check_eq("r2 c93 busy", busy_l[93], 1);
        check_golden(93);
        check_eq("r2 done c183", done_l[183], 1);
        check_eq("r2 done total", count_of(2, 0, 199), 2);

        // Run 3: abort at cycle 40
        begin_run();
        for (int c = 0; c < 120; c++) begin
            tick();
            abort = (cyc == 40);
        end
        abort = 1'b0;
        check_eq("ab rd count", count_of(0, 0, 40), 36);
        check_eq("ab busy c41", busy_l[41], 0);
        check_eq("ab rd c41", rd_l[41], 0);
        check_eq("ab stage c41", st_l[41], 0);
        check_eq("ab wr after", count_of(1, 41, 120), 0);
        check_eq("ab done", count_of(2, 0, 120), 0);
        begin_run();
        repeat (100) tick();
        check_eq("ab rerun a c1", a_l[1], 0);
        check_eq("ab rerun stage c1", st_l[1], 0);
        check_eq("ab rerun rd count", count_of(0, 0, 100), 80);
        check_eq("ab rerun wr count", count_of(1, 0, 100), 80);
        check_eq("ab rerun done c91", done_l[91], 1);

        // Run 4: reset pulse at cycle 50
        begin_run();
        for (int c = 0; c < 100; c++) begin
            tick();
            rst_n = (cyc != 50);
        end
        rst_n = 1'b1;
        check_eq("mr rd c51", rd_l[51], 0);
        check_eq("mr wr c51", wr_l[51], 0);
        check_eq("mr a c51", a_l[51], 0);
        check_eq("mr b c51", b_l[51], 0);
        check_eq("mr tw c51", tw_l[51], 0);
        check_eq("mr wa c51", wa_l[51], 0);
        check_eq("mr wb c51", wb_l[51], 0);
        check_eq("mr stage c51", st_l[51], 0);
        check_eq("mr busy c51", busy_l[51], 0);
        check_eq("mr wr c52", wr_l[52], 0);
        check_eq("mr done", count_of(2, 0, 100), 0);

        // abort together with start in IDLE: abort wins
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        check_eq("as rd_en", rd_en, 0);
        check_eq("as busy", busy, 0);
        tick();
        check_eq("as busy later", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
